cache_mtf_ctrl: RTL and testbench

Sequencing controller for the fully associative, move-to-front (MRU-at-index-0) read cache in front of program/data memory.
- Accepts one read request at a time and compares it against all cells in parallel.
- On a hit, rotates the hit cell to index 0, shifting only cells 0..hit_idx.
- On a miss, fetches the word from the backing memory, evicts the last cell and inserts the new entry at index 0.
- Owns the cell array, its valid bits and the hit/miss statistics.

---
 rtl/cache_mtf_ctrl_pkg.sv | 19 +
 rtl/cache_mtf_ctrl_if.sv | 28 ++
 rtl/cache_mtf_ctrl_array.sv | 94 +++++++++
 rtl/cache_mtf_ctrl.sv | 139 +++++++++++++
 tb/tb_cache_mtf_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cache_mtf_ctrl_pkg.sv
// Shared types for the move-to-front read cache controller.
package cache_mtf_ctrl_pkg;

    // Controller sequencing states; encodings are fixed.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLookup = 2'd1,
        StFill   = 2'd2,
        StResp   = 2'd3
    } state_e;

    // Cell-array update requested by the controller for the current cycle.
    typedef enum logic [1:0] {
        OpNone = 2'd0,
        OpHit  = 2'd1,  // rotate hit cell to index 0
        OpFill = 2'd2   // shift everything down, insert new entry at index 0
    } arr_op_e;

endpackage

// File: rtl/cache_mtf_ctrl_if.sv
// Request/response and backing-memory handshake bundle for the cache controller.
interface cache_mtf_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;

    // Environment side: requester plus backing memory.
    modport master (
        output req_valid, req_addr, rsp_ready, mem_ack, mem_data,
        input  req_ready, rsp_valid, rsp_data, mem_req, mem_addr
    );

    // Controller side.
    modport slave (
        input  req_valid, req_addr, rsp_ready, mem_ack, mem_data,
        output req_ready, rsp_valid, rsp_data, mem_req, mem_addr
    );
endinterface

// File: rtl/cache_mtf_ctrl_array.sv
// Fully associative cell array kept in MRU-first order with parallel tag compare.
module cache_mtf_ctrl_array
    import cache_mtf_ctrl_pkg::*;
#(
    parameter int unsigned CELL_CNT = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_valid_i,
    input  arr_op_e           op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);
    localparam int unsigned IDX_W = $clog2(CELL_CNT);

    logic [CELL_CNT-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]   tag_q  [CELL_CNT];
    logic [ADDR_W-1:0]   tag_d  [CELL_CNT];
    logic [DATA_W-1:0]   data_q [CELL_CNT];
    logic [DATA_W-1:0]   data_d [CELL_CNT];
    logic [CELL_CNT-1:0] match;
    logic [CELL_CNT-1:0] shift_en;
    logic [IDX_W-1:0]    hit_idx;

    // Parallel compare; the highest matching index wins.
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < CELL_CNT; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == addr_i);
            if (match[i]) hit_idx = IDX_W'(i);
        end
        hit_o      = |match;
        hit_data_o = data_q[hit_idx];
    end

    // Thermometer shift mask: cells 0..hit_idx on a hit, every cell on a fill.
    always_comb begin
        shift_en = '0;
        case (op_i)
            OpHit: begin
                for (int i = 0; i < CELL_CNT; i++) shift_en[i] = (IDX_W'(i) <= hit_idx);
            end
            OpFill:  shift_en = '1;
            default: shift_en = '0;
        endcase
    end

    // Next cell contents: index 0 takes the hit cell or the new entry, others take their predecessor.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (shift_en[0]) begin
            if (op_i == OpHit) begin
                valid_d[0] = valid_q[hit_idx];
                tag_d[0]   = tag_q[hit_idx];
                data_d[0]  = data_q[hit_idx];
            end else begin
                valid_d[0] = 1'b1;
                tag_d[0]   = addr_i;
                data_d[0]  = fill_data_i;
            end
        end
        for (int i = 1; i < CELL_CNT; i++) begin
            if (shift_en[i]) begin
                valid_d[i] = valid_q[i-1];
                tag_d[i]   = tag_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        if (clr_valid_i) valid_d = '0;
    end

    // Cell storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < CELL_CNT; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/cache_mtf_ctrl.sv
// Sequencing controller for the move-to-front read cache: FSM, handshakes, statistics.
module cache_mtf_ctrl
    import cache_mtf_ctrl_pkg::*;
#(
    parameter int unsigned CELL_CNT = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mtf_ctrl_if.slave      bus,
    input  logic                 flush,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic              req_ready;
    logic              accept;
    arr_op_e           arr_op;
    logic              arr_clr;
    logic              arr_hit;
    logic [DATA_W-1:0] arr_hit_data;

    // Ready is held low while reset is asserted and whenever a flush is pending.
    assign req_ready     = rst_n && (state_q == StIdle) && !flush;
    assign accept        = bus.req_valid && req_ready;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

    cache_mtf_ctrl_array #(
        .CELL_CNT (CELL_CNT),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_valid_i (arr_clr),
        .op_i        (arr_op),
        .addr_i      (addr_q),
        .fill_data_i (bus.mem_data),
        .hit_o       (arr_hit),
        .hit_data_o  (arr_hit_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StLookup;
            StLookup: state_d = arr_hit ? StResp : StFill;
            StFill:   if (bus.mem_ack) state_d = StResp;
            StResp:   if (rsp_valid_q && bus.rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Per-state outputs, array commands and counter updates.
    always_comb begin
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        arr_op      = OpNone;
        arr_clr     = 1'b0;
        case (state_q)
            StIdle: begin
                if (flush) arr_clr = 1'b1;
                else if (accept) addr_d = bus.req_addr;
            end
            StLookup: begin
                if (arr_hit) begin
                    arr_op      = OpHit;
                    rsp_data_d  = arr_hit_data;
                    rsp_valid_d = 1'b1;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CntOne;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CntOne;
                end
            end
            StFill: begin
                if (bus.mem_ack) begin
                    arr_op      = OpFill;
                    mem_req_d   = 1'b0;
                    rsp_data_d  = bus.mem_data;
                    rsp_valid_d = 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mtf_ctrl.sv
// Directed self-checking bench for the move-to-front cache controller.
module tb_cache_mtf_ctrl;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    int          total;
    int          bad;

    cache_mtf_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    cache_mtf_ctrl #(
        .CELL_CNT (4),
        .ADDR_W   (16),
        .DATA_W   (8),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then let LOOKUP resolve.
    task automatic issue(input logic [15:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        step();
        bus.req_valid = 1'b0;
        step();
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        bus.mem_data = d;
        bus.mem_ack  = 1'b1;
        step();
        bus.mem_ack  = 1'b0;
    endtask

    task automatic miss_fill(input string tag, input logic [15:0] a, input logic [7:0] d);
        issue(a);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        ack(d);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(d));
        finish_rsp();
    endtask

    task automatic hit_read(input string tag, input logic [15:0] a, input logic [7:0] d);
        issue(a);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(d));
        chk({tag, "_no_mem_req"}, 32'(bus.mem_req), 32'd0);
        finish_rsp();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_data  = '0;

        // Reset state
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        #10 rst_n = 1'b1;
        step();
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Cold miss on 0x0010
        issue(16'h0010);
        chk("cold_mem_req", 32'(bus.mem_req), 32'd1);
        chk("cold_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("cold_no_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        step();
        chk("cold_mem_req_held", 32'(bus.mem_req), 32'd1);
        ack(8'hA5);
        chk("cold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("cold_rsp_data", 32'(bus.rsp_data), 32'hA5);
        chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("cold_mem_req_drop", 32'(bus.mem_req), 32'd0);
        finish_rsp();
        chk("cold_rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("cold_back_idle", 32'(bus.req_ready), 32'd1);

        // Fill to order 40,30,20,10, then hit 0x20 -> 20,40,30,10
        miss_fill("fill20", 16'h0020, 8'hB2);
        miss_fill("fill30", 16'h0030, 8'hC3);
        miss_fill("fill40", 16'h0040, 8'hD4);
        chk("fill_miss_cnt", 32'(miss_cnt), 32'd4);
        hit_read("hit20", 16'h0020, 8'hB2);
        chk("hit20_cnt", 32'(hit_cnt), 32'd1);

        // Eviction: 0x50 -> 50,20,40,30 so 0x10 is gone -> 10,50,20,40
        miss_fill("miss50", 16'h0050, 8'h55);
        miss_fill("miss10", 16'h0010, 8'h11);
        // 0x20 survives only if the earlier hit moved it forward -> 20,10,50,40
        hit_read("hit20b", 16'h0020, 8'hB2);
        // 0x30 was evicted by the 0x10 fill -> 30,20,10,50
        miss_fill("miss30", 16'h0030, 8'h33);
        chk("evict_miss_cnt", 32'(miss_cnt), 32'd7);
        // Index-0 hit leaves order alone; index-3 hits rotate the full array
        hit_read("hit30_idx0", 16'h0030, 8'h33);
        hit_read("hit50_idx3", 16'h0050, 8'h55);
        hit_read("hit10_idx3", 16'h0010, 8'h11);
        chk("hits_cnt", 32'(hit_cnt), 32'd5);

        // Backpressure: response held stable for five cycles
        issue(16'h0010);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(bus.rsp_data), 32'h11);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        finish_rsp();
        chk("bp_released", 32'(bus.rsp_valid), 32'd0);
        chk("bp_back_idle", 32'(bus.req_ready), 32'd1);
        chk("bp_hit_cnt", 32'(hit_cnt), 32'd6);

        // Flush beats a simultaneous request
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0020;
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        chk("flush_no_mem_req", 32'(bus.mem_req), 32'd0);
        chk("flush_no_rsp", 32'(bus.rsp_valid), 32'd0);
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("flush_not_taken", 32'(bus.req_ready), 32'd1);
        miss_fill("post_flush20", 16'h0020, 8'h77);
        chk("flush_keeps_hits", 32'(hit_cnt), 32'd6);
        chk("flush_miss_cnt", 32'(miss_cnt), 32'd8);

        // Reset in FILL abandons the memory transaction
        issue(16'h0099);
        chk("rfill_mem_req", 32'(bus.mem_req), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rfill_mem_req_clr", 32'(bus.mem_req), 32'd0);
        chk("rfill_mem_addr_clr", 32'(bus.mem_addr), 32'd0);
        chk("rfill_miss_cnt_clr", 32'(miss_cnt), 32'd0);
        chk("rfill_hit_cnt_clr", 32'(hit_cnt), 32'd0);
        #2 rst_n = 1'b1;
        ack(8'hEE);
        chk("stray_ack_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("stray_ack_idle", 32'(bus.req_ready), 32'd1);
        chk("stray_ack_no_mem", 32'(bus.mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
